// File: rtl/vga_rect_fill_ctrl.sv
// Rectangle-fill engine: AHB-lite config slave plus AHB-lite write master that
// paints a rectangle of the 320x240 framebuffer one 32-bit word per pixel, in raster order.
module vga_rect_fill_ctrl #(
  parameter logic [31:0] FbBase   = 32'h0000_0000,
  parameter int unsigned FbWidth  = 320,
  parameter int unsigned FbHeight = 240
) (
  input  logic        i_hclk,
  input  logic        i_hreset,
  input  logic        i_hsel,
  input  logic        i_hready,
  input  logic        i_hwrite,
  input  logic [1:0]  i_htrans,
  input  logic [31:0] i_haddr,
  input  logic [31:0] i_hwdata,
  output logic        o_hreadyout,
  output logic [31:0] o_hrdata,
  output logic [1:0]  o_m_htrans,
  output logic [31:0] o_m_haddr,
  output logic [31:0] o_m_hwdata,
  output logic        o_m_hwrite,
  output logic [2:0]  o_m_hsize,
  input  logic        i_m_hready,
  output logic        o_irq
);

  localparam logic [8:0]  LpWidth  = 9'(FbWidth);
  localparam logic [8:0]  LpHeight = 9'(FbHeight);
  localparam logic [31:0] LpStride = 32'(FbWidth * 4);
  localparam logic [1:0]  HtIdle   = 2'b00;
  localparam logic [1:0]  HtNonseq = 2'b10;

  typedef enum logic [1:0] {StIdle, StCheck, StIssue, StDrain} state_e;

  state_e r_state, w_state_nxt;

  // Config slave address-phase capture and programmed registers
  logic [3:0]  r_addr;
  logic        r_wr;
  logic [8:0]  r_x0, r_y0, r_x1, r_y1;
  logic [11:0] r_color;
  logic        r_irq_en;

  // Working copy of the rectangle, frozen at START
  logic [8:0]  r_wx0, r_wy0, r_wx1, r_wy1;
  logic [11:0] r_wcolor;
  logic [8:0]  r_x, r_y;
  logic [31:0] r_row_base;

  // Status
  logic r_done, r_err, r_aborted, r_abort_pend;

  logic w_addr_ph, w_wr_ctrl, w_start, w_clear, w_abort, w_rect_ok, w_last, w_advance;
  logic w_unused;

  assign w_addr_ph = i_hsel & i_htrans[1] & i_hready;
  assign w_wr_ctrl = r_wr & (r_addr == 4'hC);
  assign w_start   = w_wr_ctrl & i_hwdata[0] & (r_state == StIdle);
  assign w_clear   = w_wr_ctrl & i_hwdata[1];
  assign w_abort   = w_wr_ctrl & i_hwdata[3] & (r_state == StIssue);
  assign w_rect_ok = (r_wx0 <= r_wx1) & (r_wy0 <= r_wy1) & (r_wx1 < LpWidth) & (r_wy1 < LpHeight);
  assign w_last    = (r_x == r_wx1) & (r_y == r_wy1);
  assign w_advance = (r_state == StIssue) & i_m_hready & ~w_last;

  assign o_hreadyout = 1'b1;
  assign o_m_hsize   = 3'b010;
  assign o_m_haddr   = r_row_base + {21'h0, r_x, 2'b00};
  assign o_m_hwdata  = {20'h0, r_wcolor};
  assign o_irq       = r_done & r_irq_en;
  assign w_unused    = ^{i_haddr[31:4], i_hwdata[31:25], i_hwdata[15:12], i_htrans[0]};

  // Capture the slave address phase; the write data lands one cycle later
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_addr <= 4'h0;
      r_wr   <= 1'b0;
    end else begin
      r_wr <= w_addr_ph & i_hwrite;
      if (w_addr_ph) r_addr <= i_haddr[3:0];
    end
  end

  // Programmed configuration registers
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_color  <= '0;
      r_irq_en <= 1'b0;
    end else if (r_wr) begin
      case (r_addr)
        4'h0: begin
          r_x0 <= i_hwdata[24:16];
          r_y0 <= i_hwdata[8:0];
        end
        4'h4: begin
          r_x1 <= i_hwdata[24:16];
          r_y1 <= i_hwdata[8:0];
        end
        4'h8: r_color  <= i_hwdata[11:0];
        4'hC: r_irq_en <= i_hwdata[2];
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_hclk) begin
    if (i_hreset) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and master control outputs
  always_comb begin
    w_state_nxt = r_state;
    o_m_htrans  = HtIdle;
    o_m_hwrite  = 1'b0;
    case (r_state)
      StIdle:  if (w_start) w_state_nxt = StCheck;
      StCheck: w_state_nxt = w_rect_ok ? StIssue : StIdle;
      StIssue: begin
        o_m_htrans = HtNonseq;
        o_m_hwrite = 1'b1;
        // An abort only takes effect once the current address phase is accepted
        if (i_m_hready && (w_last || w_abort || r_abort_pend)) w_state_nxt = StDrain;
      end
      StDrain: if (i_m_hready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Working rectangle and pixel walker; row_base steps by one stride per row
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_wx0      <= '0;
      r_wy0      <= '0;
      r_wx1      <= '0;
      r_wy1      <= '0;
      r_wcolor   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
    end else begin
      if (w_start) begin
        r_wx0    <= r_x0;
        r_wy0    <= r_y0;
        r_wx1    <= r_x1;
        r_wy1    <= r_y1;
        r_wcolor <= r_color;
      end
      if (r_state == StCheck) begin
        r_x        <= r_wx0;
        r_y        <= r_wy0;
        r_row_base <= FbBase + ({23'h0, r_wy0} * LpStride);
      end else if (w_advance) begin
        if (r_x == r_wx1) begin
          r_x        <= r_wx0;
          r_y        <= r_y + 9'd1;
          r_row_base <= r_row_base + LpStride;
        end else begin
          r_x <= r_x + 9'd1;
        end
      end
    end
  end

  // Status flags; a set in the same cycle as a software clear wins
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_clear) begin
        r_done    <= 1'b0;
        r_err     <= 1'b0;
        r_aborted <= 1'b0;
      end
      if (w_abort) r_abort_pend <= 1'b1;
      if ((r_state == StCheck) && !w_rect_ok) begin
        r_err  <= 1'b1;
        r_done <= 1'b1;
      end
      if ((r_state == StDrain) && i_m_hready) begin
        r_done       <= 1'b1;
        r_aborted    <= r_aborted | r_abort_pend;
        r_abort_pend <= 1'b0;
      end
    end
  end

  // Read mux driven by the captured address
  always_comb begin
    o_hrdata = 32'hCCCC_CCCC;
    case (r_addr)
      4'h0: o_hrdata = {7'h0, r_x0, 7'h0, r_y0};
      4'h4: o_hrdata = {7'h0, r_x1, 7'h0, r_y1};
      4'h8: o_hrdata = {20'h0, r_color};
      4'hC: o_hrdata = {27'h0, r_err, r_aborted, r_irq_en, r_done, (r_state != StIdle)};
      default: o_hrdata = 32'hCCCC_CCCC;
    endcase
  end

endmodule

// File: tb/tb_vga_rect_fill_ctrl.sv
// Self-checking bench for vga_rect_fill_ctrl: vector table, cycle-exact sequences,
// randomized rectangles against a raster-order address model.
module tb_vga_rect_fill_ctrl;

  localparam int          W       = 320;
  localparam int          H       = 240;
  localparam logic [31:0] FB_BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0, hready = 1'b1, hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = '0, hwdata = '0;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [1:0]  m_htrans;
  logic [31:0] m_haddr, m_hwdata;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic        m_hready = 1'b1;
  logic        irq;

  always #5 clk = ~clk;

  vga_rect_fill_ctrl dut (
    .i_hclk      (clk),
    .i_hreset    (hreset),
    .i_hsel      (hsel),
    .i_hready    (hready),
    .i_hwrite    (hwrite),
    .i_htrans    (htrans),
    .i_haddr     (haddr),
    .i_hwdata    (hwdata),
    .o_hreadyout (hreadyout),
    .o_hrdata    (hrdata),
    .o_m_htrans  (m_htrans),
    .o_m_haddr   (m_haddr),
    .o_m_hwdata  (m_hwdata),
    .o_m_hwrite  (m_hwrite),
    .o_m_hsize   (m_hsize),
    .i_m_hready  (m_hready),
    .o_irq       (irq)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] exp_color = '0;
  logic [31:0] got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_pos(input int x, input int y);
    logic [31:0] xv, yv;
    xv = 32'(x);
    yv = 32'(y);
    return {7'h0, xv[8:0], 7'h0, yv[8:0]};
  endfunction

  // Framebuffer slave ready: 30% wait states when randomized
  initial forever begin
    @(posedge clk);
    #1;
    m_hready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
  end

  // Bus monitor: records accepted beats, checks data phases and stall holding
  bit          dp_pending = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  initial forever begin
    @(negedge clk);
    if (hreset) begin
      dp_pending = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_htrans", {30'h0, m_htrans}, 32'h2);
        chk("stall_hold_haddr", m_haddr, prev_addr);
      end
      if (dp_pending && m_hready) begin
        chk("data_phase_hwdata", m_hwdata, exp_color);
        dp_pending = 1'b0;
      end
      if (m_htrans == 2'b10 && m_hready) begin
        got_q.push_back(m_haddr);
        dp_pending = 1'b1;
        chk("addr_phase_hwrite", {31'h0, m_hwrite}, 32'h1);
      end
      prev_stall = (m_htrans == 2'b10) && !m_hready;
      prev_addr  = m_haddr;
    end
  end

  // All bus tasks are entered and left 1 time unit after a rising edge
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    @(posedge clk); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    d = hrdata;
  endtask

  task automatic program_rect(input int x0, input int y0, input int x1, input int y1,
                              input logic [11:0] col);
    ahb_write(32'h0, pack_pos(x0, y0));
    ahb_write(32'h4, pack_pos(x1, y1));
    ahb_write(32'h8, {20'h0, col});
  endtask

  task automatic wait_done(output logic [31:0] st);
    bit ok;
    ok = 1'b0;
    st = '0;
    for (int i = 0; i < 20000; i++) begin
      ahb_read(32'hC, st);
      if (st[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_within_budget", {31'h0, ok}, 32'h1);
  endtask

  // Program, clear, start, wait, then compare against the raster-order model
  task automatic do_fill(input int x0, input int y0, input int x1, input int y1,
                         input logic [11:0] col, output logic [31:0] st);
    logic [31:0] exp_q[$];
    int          nmis;
    int          nmin;
    bit          valid;
    program_rect(x0, y0, x1, y1, col);
    ahb_write(32'hC, 32'h2);
    got_q.delete();
    exp_color = {20'h0, col};
    ahb_write(32'hC, 32'h1);
    wait_done(st);
    valid = (x0 <= x1) && (y0 <= y1) && (x1 < W) && (y1 < H);
    if (valid)
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++)
          exp_q.push_back(FB_BASE + 32'((y * W + x) * 4));
    chk("model_beat_count", 32'(got_q.size()), 32'(exp_q.size()));
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    nmis = 0;
    for (int i = 0; i < nmin; i++) if (got_q[i] !== exp_q[i]) nmis++;
    chk("model_addr_order", 32'(nmis), 32'h0);
    chk("model_status", st, valid ? 32'h2 : 32'h12);
  endtask

  typedef struct {
    int          x0, y0, x1, y1;
    logic [11:0] col;
    int          npix;
    logic [31:0] last;
    logic [31:0] status;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    logic [31:0] st;
    logic [31:0] ta[4];
    int          n_at;
    int          rx0, ry0, rx1, ry1;

    tbl[0] = '{0,   0,   1,   1,   12'hF00, 4,     32'h0000_0504, 32'h2};
    tbl[1] = '{5,   0,   4,   0,   12'h0AA, 0,     32'h0,         32'h12};
    tbl[2] = '{0,   0,   0,   240, 12'h0BB, 0,     32'h0,         32'h12};
    tbl[3] = '{319, 239, 319, 239, 12'hFFF, 1,     32'h0004_AFFC, 32'h2};
    tbl[4] = '{10,  5,   12,  6,   12'h123, 6,     32'h0000_1E30, 32'h2};
    tbl[5] = '{0,   0,   320, 0,   12'h456, 0,     32'h0,         32'h12};
    tbl[6] = '{0,   5,   0,   4,   12'h789, 0,     32'h0,         32'h12};
    tbl[7] = '{100, 200, 109, 201, 12'hABC, 20,    32'h0003_EEB4, 32'h2};
    tbl[8] = '{0,   200, 319, 239, 12'h5A5, 12800, 32'h0004_AFFC, 32'h2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    hreset = 1'b0;
    chk("rst_m_htrans", {30'h0, m_htrans}, 32'h0);
    chk("rst_m_haddr", m_haddr, 32'h0);
    chk("rst_m_hwdata", m_hwdata, 32'h0);
    chk("rst_m_hwrite", {31'h0, m_hwrite}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_hreadyout", {31'h0, hreadyout}, 32'h1);
    chk("rst_m_hsize", {29'h0, m_hsize}, 32'h2);
    ahb_read(32'h2, st);
    chk("unmapped_read", st, 32'hCCCC_CCCC);

    // Cycle-exact 2x2 fill, bus always ready
    rand_ready = 1'b0;
    program_rect(0, 0, 1, 1, 12'hF00);
    ahb_write(32'hC, 32'h2);
    got_q.delete();
    exp_color = 32'h0000_0F00;
    ta[0] = 32'h0; ta[1] = 32'h4; ta[2] = 32'h500; ta[3] = 32'h504;
    ahb_write(32'hC, 32'h1);
    chk("t1_check_htrans_idle", {30'h0, m_htrans}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("tn_htrans_nonseq", {30'h0, m_htrans}, 32'h2);
      chk("tn_haddr", m_haddr, ta[i]);
    end
    @(posedge clk); #1;
    chk("t6_drain_idle", {30'h0, m_htrans}, 32'h0);
    ahb_read(32'hC, st);
    chk("t7_status_done", st, 32'h2);
    chk("t7_beats", 32'(got_q.size()), 32'h4);

    // Vector table with random wait states
    rand_ready = 1'b1;
    foreach (tbl[i]) begin
      do_fill(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].col, st);
      chk("tbl_npix", 32'(got_q.size()), 32'(tbl[i].npix));
      chk("tbl_status", st, tbl[i].status);
      if (got_q.size() > 0) chk("tbl_last_addr", got_q[$], tbl[i].last);
    end

    // Randomized small rectangles, some invalid
    for (int k = 0; k < 8; k++) begin
      rx0 = int'($urandom_range(0, 325));
      rx1 = rx0 + int'($urandom_range(0, 6)) - 1;
      if (rx1 < 0) rx1 = 0;
      ry0 = int'($urandom_range(0, 245));
      ry1 = ry0 + int'($urandom_range(0, 4)) - 1;
      if (ry1 < 0) ry1 = 0;
      do_fill(rx0, ry0, rx1, ry1, 12'($urandom), st);
    end

    // Abort after 10 accepted beats of a 100-pixel fill
    rand_ready = 1'b0;
    program_rect(0, 0, 99, 0, 12'h0AB);
    ahb_write(32'hC, 32'h2);
    got_q.delete();
    exp_color = 32'h0000_00AB;
    ahb_write(32'hC, 32'h1);
    ahb_read(32'hC, st);
    chk("abort_busy_status", st, 32'h1);
    for (int i = 0; i < 200 && got_q.size() < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach_10", {31'h0, got_q.size() >= 10}, 32'h1);
    ahb_write(32'hC, 32'h8);
    chk("abort_htrans_idle", {30'h0, m_htrans}, 32'h0);
    n_at = got_q.size();
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_no_more_beats", 32'(got_q.size()), 32'(n_at));
    wait_done(st);
    chk("abort_status", st, 32'hA);
    chk("abort_lt_100", {31'h0, got_q.size() < 100}, 32'h1);
    chk("abort_last_addr", got_q[$], 32'((got_q.size() - 1) * 4));

    // IRQ, ignored START while busy, config writes not affecting a running fill
    rand_ready = 1'b1;
    program_rect(0, 0, 49, 0, 12'h123);
    ahb_write(32'hC, 32'h6);
    got_q.delete();
    exp_color = 32'h0000_0123;
    ahb_write(32'hC, 32'h5);
    ahb_write(32'h4, pack_pos(99, 0));
    ahb_write(32'hC, 32'h5);
    wait_done(st);
    chk("busy_start_beats", 32'(got_q.size()), 32'd50);
    chk("busy_start_last", got_q[$], 32'h0000_00C4);
    chk("irq_status", st, 32'h6);
    chk("irq_high", {31'h0, irq}, 32'h1);
    ahb_write(32'hC, 32'h6);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    ahb_read(32'hC, st);
    chk("irq_cleared_status", st, 32'h4);

    // Synchronous reset in the middle of a fill
    rand_ready = 1'b0;
    program_rect(0, 0, 99, 0, 12'h077);
    ahb_write(32'hC, 32'h2);
    exp_color = 32'h0000_0077;
    ahb_write(32'hC, 32'h1);
    repeat (20) begin
      @(posedge clk); #1;
    end
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    chk("midrst_htrans", {30'h0, m_htrans}, 32'h0);
    chk("midrst_haddr", m_haddr, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    ahb_read(32'hC, st);
    chk("midrst_status", st, 32'h0);
    ahb_read(32'h4, st);
    chk("midrst_pos1", st, 32'h0);
    do_fill(2, 3, 4, 3, 12'h0F0, st);
    chk("after_rst_last", got_q[$], 32'((3 * W + 4) * 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
